conv_enc_punct: RTL and testbench
=================================

// Module: conv_enc_punct
// PURPOSE
//  Parametrised rate-1/2 convolutional encoder (802.11a K=7, 133/171 octal) with per-frame
//  puncturing to 2/3 or 3/4. Emits a serial coded-bit stream under valid/ready backpressure.
//  Sits between the scrambler and the interleaver in the TX chain.
// PARAMETERS
//  K      7          constraint length (shift register holds K-1 past bits)
//  G0     7'o133     generator for coded bit A; G0[K-1] taps the current input
//  G1     7'o171     generator for coded bit B; same tap convention
// PORTS
//  sys_clk    in   1  clock, rising edge
//  sys_rstn   in   1  async reset, active-low
//  in_data    in   1  uncoded (scrambled) bit
//  in_valid   in   1  in_data valid
//  in_ready   out  1  beat accepted when in_valid & in_ready
//  in_sof     in   1  first bit of frame; qualifies rate
//  in_last    in   1  last data bit of frame
//  rate       in   2  00=1/2, 01=2/3, 10=3/4, 11=reserved; sampled on accepted sof beat
//  out_data   out  1  coded bit
//  out_valid  out  1  out_data valid
//  out_ready  in   1  downstream accepts when out_valid & out_ready
//  out_last   out  1  with out_valid: last coded bit of frame
//  busy       out  1  frame in progress (sof accepted, final out_last not yet accepted)
//  rate_err   out  1  1-cycle pulse: sof accepted with rate=11
// BEHAVIOUR
//  Reset: shift reg=0, phase=0, rate_q=00, pending=0; in_ready=1, out_valid=0, out_last=0,
//   busy=0, rate_err=0. Reset mid-frame discards all pending bits; no out_last is issued.
//  Encode: v[0]=current bit, v[i]=bit i beats earlier. A=^ v[i] where G0[K-1-i]=1; B likewise with G1.
//  An accepted sof beat encodes with past state forced to 0 (register cleared) and resets phase to 0.
//  Puncture (per-frame phase counter, wraps at period): 1/2: emit A,B. 2/3 (period 2):
//   ph0 A,B; ph1 A. 3/4 (period 3): ph0 A,B; ph1 A; ph2 B. Emission order A before B.
//  rate=11 is encoded as 1/2 and pulses rate_err. rate is ignored on non-sof beats.
//  Holding buffer: up to 2 pending bits. in_ready = pending==0 | (pending==1 & out fire).
//   Next pending bits load in the same cycle the last pending bit leaves: no bubble.
//  Latency: beat accepted at cycle t -> its first coded bit out_valid at t+1.
//  out_data/out_valid/out_last are stable while out_valid & !out_ready.
//  Short frame: a frame ending mid-period emits only the current phase's bits; no padding.
//  sof while busy: protocol error; new frame restarts (state/phase cleared), the
//   old frame's out_last is never issued.
//  Single-bit frame (sof&last together) is legal.
// CONFIGURATION
//  CONV_TAIL_FLUSH_EN defined: after accepting in_last, FSM RUN->TAIL: in_ready=0,
//   K-1 zero bits are encoded internally, punctured with the continuing phase;
//   out_last marks the final tail coded bit, then the FSM returns to IDLE and the
//   shift register ends at 0. FSM: IDLE -(sof)-> RUN -(last)-> TAIL -(K-1 done & drained)-> IDLE.
//  Not defined: no tail; out_last marks the final coded bit of the in_last beat; FSM IDLE/RUN only.
// STRUCTURE
//  Package ofdm_tx_pkg: rate_t enum (RATE_1_2, RATE_2_3, RATE_3_4, RATE_RSVD),
//   puncture keep-masks per rate/phase, default K/G0/G1 constants.
//  Sub-module conv_enc_core: K-1 shift register + G0/G1 XOR trees, enable and sync clear.
//  Top holds the rate latch, phase counter, holding buffer/serialiser and FSM.
// TESTING
//  Impulse 1,0,0,0,0,0,0 (sof/last), rate 1/2, out_ready=1 -> 11 01 11 11 00 10 11, out_last on bit 14.
//  Bits 1,0,0,0 rate 2/3 -> 110111 (6 bits); bits 1,0,0,0,0,0 rate 3/4 -> 11011100 (8 bits).
//  Random 1000-bit frames, out_ready random 30% low -> output matches reference model, no loss/dup.
//  sof with rate=11 -> 1-cycle rate_err, output identical to rate 1/2.
//  CONV_TAIL_FLUSH_EN, impulse single bit rate 1/2 -> 14 bits as above, last tail bit has out_last, busy drops.
//  Async reset asserted mid-frame -> outputs at reset values next edge; next frame encodes from zero state.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared types and constants for the OFDM TX chain: code rates, encoder FSM states,
// puncture keep-masks per rate/phase, and the default 802.11a K=7 133/171 generators.
// Pure declarations; no latency or backpressure of its own.
package ofdm_tx_pkg;

    localparam int         CONV_K  = 7;
    localparam logic [6:0] CONV_G0 = 7'o133;
    localparam logic [6:0] CONV_G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TAIL
    } enc_state_t;

    // Keep-mask for one encoded beat, returned as {keep_B, keep_A}.
    // The reserved rate falls into the default branch and is sent unpunctured.
    function automatic logic [1:0] punct_keep(rate_t r, logic [1:0] ph);
        logic [1:0] keep;
        keep = 2'b11;
        case (r)
            RATE_2_3: if (ph == 2'd1) keep = 2'b01;
            RATE_3_4: begin
                if (ph == 2'd1)      keep = 2'b01;
                else if (ph == 2'd2) keep = 2'b10;
            end
            default:  keep = 2'b11;
        endcase
        return keep;
    endfunction

    // Phase after the current beat; wraps at the puncture period (1, 2 or 3).
    function automatic logic [1:0] punct_next_phase(rate_t r, logic [1:0] ph);
        logic [1:0] nxt;
        nxt = 2'd0;
        case (r)
            RATE_2_3: nxt = (ph == 2'd0) ? 2'd1 : 2'd0;
            RATE_3_4: nxt = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            default:  nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core: K-1 bit history register plus two XOR trees.
// Latency: coded bits A/B are combinational from din_i and the stored history.
// Backpressure: none; the history only advances when en_i is high.
// Ports: en_i advances the history, clr_i forces the history to zero for this beat,
//        din_i is the current bit, a_o/b_o are the G0/G1 coded bits.
module conv_enc_core
    import ofdm_tx_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic sys_clk,
    input  logic sys_rstn,
    input  logic en_i,
    input  logic clr_i,
    input  logic din_i,
    output logic a_o,
    output logic b_o
);

    // sr_q[0] is the previous bit, sr_q[i] the bit i+1 beats ago.
    logic [K-2:0] sr_q, sr_d, past;
    logic [K-1:0] v, tap0, tap1;

    // Generators put the current-input tap at the MSB; reverse them so tap[i]
    // lines up with v[i] (the bit i beats ago).
    for (genvar i = 0; i < K; i++) begin : g_tap
        assign tap0[i] = G0[K-1-i];
        assign tap1[i] = G1[K-1-i];
    end

    assign past = clr_i ? '0 : sr_q;
    assign v    = {past, din_i};
    assign a_o  = ^(v & tap0);
    assign b_o  = ^(v & tap1);

    always_comb begin
        sr_d = sr_q;
        if (en_i)       sr_d = {past[K-3:0], din_i};
        else if (clr_i) sr_d = '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) sr_q <= '0;
        else           sr_q <= sr_d;
    end

endmodule

// File: rtl/conv_enc_punct.sv
// K=7 convolutional encoder with per-frame puncturing (1/2, 2/3, 3/4) and serial output.
// Latency: a beat accepted at cycle t presents its first coded bit at t+1.
// Backpressure: 2-bit holding buffer; in_ready only when it will be empty next cycle.
// Ports: in_* uncoded bit stream (valid/ready, sof/last framing, rate on sof),
//        out_* serial coded bits (valid/ready, last), busy = frame in flight,
//        rate_err = one-cycle pulse after a sof with the reserved rate.
// Build option: CONV_TAIL_FLUSH_EN appends K-1 zero tail bits after in_last.
module conv_enc_punct
    import ofdm_tx_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic       in_last,
    input  logic [1:0] rate,
    output logic       out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       rate_err
);

    enc_state_t state_q, state_d;
    rate_t      rate_q, rate_d, beat_rate;
    logic [1:0] phase_q, phase_d, beat_phase;
    logic [1:0] buf_q, buf_d;      // buf_q[0] is the bit on out_data
    logic [1:0] cnt_q, cnt_d;      // pending coded bits, 0..2
    logic       last_q, last_d;    // the final pending bit closes the frame
    logic       rate_err_q, rate_err_d;
    logic       out_fire, slot_free, in_fire, sof_fire, tail_load, load;
    logic       enc_din, enc_a, enc_b;
    logic [1:0] keep;
`ifdef CONV_TAIL_FLUSH_EN
    localparam int TW = $clog2(K);
    logic [TW-1:0] tail_q, tail_d;  // tail bits still to be encoded
`endif

    assign out_fire  = out_valid & out_ready;
    // A new beat may load when the buffer is empty or its last bit leaves now,
    // so consecutive beats stream without a bubble.
    assign slot_free = (cnt_q == 2'd0) | ((cnt_q == 2'd1) & out_fire);
    assign in_ready  = slot_free & (state_q != ST_TAIL);
    assign in_fire   = in_valid & in_ready;
    assign sof_fire  = in_fire & in_sof;
`ifdef CONV_TAIL_FLUSH_EN
    assign tail_load = slot_free & (state_q == ST_TAIL) & (tail_q != '0);
`else
    assign tail_load = 1'b0;
`endif
    assign load      = in_fire | tail_load;
    assign enc_din   = in_fire & in_data;   // tail beats encode zeros

    // The sof beat itself uses the freshly presented rate and phase 0.
    assign beat_rate  = sof_fire ? rate_t'(rate) : rate_q;
    assign beat_phase = sof_fire ? 2'd0 : phase_q;
    assign keep       = punct_keep(beat_rate, beat_phase);

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf_q[0];
    assign out_last  = (cnt_q == 2'd1) & last_q;
    assign busy      = (state_q != ST_IDLE);
    assign rate_err  = rate_err_q;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .en_i     (load),
        .clr_i    (sof_fire),
        .din_i    (enc_din),
        .a_o      (enc_a),
        .b_o      (enc_b)
    );

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        phase_d    = phase_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rate_err_d = sof_fire & (rate_t'(rate) == RATE_RSVD);
`ifdef CONV_TAIL_FLUSH_EN
        tail_d     = tail_q;
`endif

        if (out_fire) begin
            buf_d = {1'b0, buf_q[1]};
            cnt_d = cnt_q - 2'd1;
        end

        if (load) begin
            phase_d = punct_next_phase(beat_rate, beat_phase);
            case (keep)
                2'b11: begin buf_d = {enc_b, enc_a}; cnt_d = 2'd2; end
                2'b10: begin buf_d = {1'b0, enc_b};  cnt_d = 2'd1; end
                default: begin buf_d = {1'b0, enc_a}; cnt_d = 2'd1; end
            endcase
`ifdef CONV_TAIL_FLUSH_EN
            last_d = tail_load & (tail_q == TW'(1));
`else
            last_d = in_last;
`endif
        end

        if (sof_fire) rate_d = rate_t'(rate);

        case (state_q)
            ST_IDLE, ST_RUN: begin
`ifndef CONV_TAIL_FLUSH_EN
                if (out_fire & out_last) state_d = ST_IDLE;
`endif
                // A sof while busy simply restarts the frame.
                if (sof_fire) state_d = ST_RUN;
`ifdef CONV_TAIL_FLUSH_EN
                if (in_fire & in_last & (in_sof | (state_q == ST_RUN))) begin
                    state_d = ST_TAIL;
                    tail_d  = TW'(K - 1);
                end
`endif
            end
            ST_TAIL: begin
`ifdef CONV_TAIL_FLUSH_EN
                if (tail_load) tail_d = tail_q - 1'b1;
                if (out_fire & out_last) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= ST_IDLE;
            rate_q     <= RATE_1_2;
            phase_q    <= 2'd0;
            buf_q      <= 2'd0;
            cnt_q      <= 2'd0;
            last_q     <= 1'b0;
            rate_err_q <= 1'b0;
`ifdef CONV_TAIL_FLUSH_EN
            tail_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            phase_q    <= phase_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rate_err_q <= rate_err_d;
`ifdef CONV_TAIL_FLUSH_EN
            tail_q     <= tail_d;
`endif
        end
    end

endmodule

// File: tb/tb_conv_enc_punct.sv
// Bench for conv_enc_punct: fixed vectors, random frames against a reference model,
// reset and restart corner cases.
module tb_conv_enc_punct;

    logic       sys_clk = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       in_data = 1'b0, in_valid = 1'b0, in_sof = 1'b0, in_last = 1'b0;
    logic [1:0] rate = 2'd0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_data, out_valid, out_last, busy, rate_err;

    always #5 sys_clk = ~sys_clk;

    conv_enc_punct dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_last   (in_last),
        .rate      (rate),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .rate_err  (rate_err)
    );

    localparam int G0_OCT = 'o133;
    localparam int G1_OCT = 'o171;
`ifdef CONV_TAIL_FLUSH_EN
    localparam int TAIL_N = 6;
`else
    localparam int TAIL_N = 0;
`endif

    typedef struct {
        logic [15:0] din;
        int          dlen;
        logic [1:0]  rate;
        logic [31:0] exp;
        int          elen;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    bit   tx_bits[$], tx_sof[$], rx_bits[$], exp_bits[$];
    int   rerr_cnt, lat;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [15:0] d, input int dl, input logic [1:0] r,
                                    input logic [31:0] e, input int el);
        vec_t v;
        v = '{d, dl, r, e, el};
        tbl.push_back(v);
    endfunction

    // Reference: direct convolution of one segment, then the puncture pattern
    // selected by (beat index mod period).
    function automatic void encode_seg(input bit s[$], input logic [1:0] r, input int ntail);
        int per;
        int a;
        int b;
        int ph;
        per = (r == 2'd1) ? 2 : (r == 2'd2) ? 3 : 1;
        for (int t = 0; t < ntail; t++) s.push_back(1'b0);
        for (int j = 0; j < s.size(); j++) begin
            a = 0;
            b = 0;
            ph = j % per;
            for (int i = 0; i < 7; i++) begin
                if (j >= i) begin
                    a += int'(s[j-i]) * ((G0_OCT >> (6 - i)) & 1);
                    b += int'(s[j-i]) * ((G1_OCT >> (6 - i)) & 1);
                end
            end
            if (!(r == 2'd2 && ph == 2)) exp_bits.push_back(bit'(a % 2));
            if (ph == 0 || (r == 2'd2 && ph == 2)) exp_bits.push_back(bit'(b % 2));
        end
    endfunction

    function automatic void build_expect(input logic [1:0] r);
        bit seg[$];
        exp_bits.delete();
        for (int i = 0; i < tx_bits.size(); i++) begin
            if (tx_sof[i] && seg.size() > 0) begin
                encode_seg(seg, r, 0);
                seg.delete();
            end
            seg.push_back(tx_bits[i]);
        end
        encode_seg(seg, r, TAIL_N);
    endfunction

    // Drives tx_bits (sof where tx_sof is set, last on the final bit), collects the
    // output stream until out_last, checks hold-under-stall and busy afterwards.
    task automatic run_frame(input logic [1:0] r, input int low_pct, input string tag);
        int   idx;
        int   cyc;
        int   budget;
        int   acc_cyc;
        int   ov_cyc;
        bit   done;
        bit   stall;
        logic pd;
        logic pl;
        idx = 0; cyc = 0; done = 0; stall = 0; acc_cyc = -1; ov_cyc = -1;
        pd = 1'b0; pl = 1'b0; rerr_cnt = 0;
        budget = 30 * tx_bits.size() + 200;
        rx_bits.delete();
        while (!done && cyc < budget) begin
            @(negedge sys_clk);
            out_ready = ($urandom_range(0, 99) >= low_pct);
            if (idx < tx_bits.size()) begin
                in_valid = 1'b1;
                in_data  = tx_bits[idx];
                in_sof   = tx_sof[idx];
                in_last  = (idx == tx_bits.size() - 1);
                rate     = tx_sof[idx] ? r : 2'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0; in_data = 1'b0; in_sof = 1'b0; in_last = 1'b0;
            end
            #1;
            if (stall) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === pd && out_last === pl)) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%b l=%b, expected v=1 d=%b l=%b",
                             tag, out_valid, out_data, out_last, pd, pl);
                end
            end
            stall = (out_valid === 1'b1) && !out_ready;
            pd = out_data;
            pl = out_last;
            if (rate_err === 1'b1) rerr_cnt++;
            if (out_valid === 1'b1 && ov_cyc < 0) ov_cyc = cyc;
            if (in_valid && in_ready === 1'b1) begin
                if (idx == 0) acc_cyc = cyc;
                idx++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                rx_bits.push_back(out_data);
                if (out_last === 1'b1) done = 1;
            end
            cyc++;
        end
        check({tag, " out_last_seen"}, int'(done), 1);
        lat = ov_cyc - acc_cyc;
        @(negedge sys_clk);
        in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0; in_data = 1'b0;
        #1;
        check({tag, " busy_after"}, int'(busy), 0);
    endtask

    task automatic compare_stream(input string tag);
        int mism;
        int first;
        mism = 0;
        first = -1;
        for (int k = 0; k < exp_bits.size() && k < rx_bits.size(); k++) begin
            if (rx_bits[k] != exp_bits[k]) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        check({tag, " stream_len"}, rx_bits.size(), exp_bits.size());
        check({tag, " bit_mismatches"}, mism, 0);
        if (first >= 0) $display("  first differing bit index %0d", first);
    endtask

    task automatic load_vec(input int v);
        logic [15:0] d;
        logic [31:0] e;
        d = tbl[v].din;
        e = tbl[v].exp;
        tx_bits.delete(); tx_sof.delete(); exp_bits.delete();
        for (int k = 0; k < tbl[v].dlen; k++) begin
            tx_bits.push_back(d[tbl[v].dlen-1-k]);
            tx_sof.push_back(k == 0);
        end
        for (int k = 0; k < tbl[v].elen; k++) exp_bits.push_back(e[tbl[v].elen-1-k]);
    endtask

    task automatic run_vec(input int v, input string tag);
        load_vec(v);
        run_frame(tbl[v].rate, 0, tag);
        compare_stream(tag);
        check({tag, " latency"}, lat, 1);
        check({tag, " rate_err_pulses"}, rerr_cnt, (tbl[v].rate == 2'd3) ? 1 : 0);
    endtask

    initial begin
        int         vcnt;
        int         len;
        logic [1:0] r;
`ifdef CONV_TAIL_FLUSH_EN
        add_vec(16'b1,    1, 2'd0, 32'b11011111001011, 14);
        add_vec(16'b1,    1, 2'd3, 32'b11011111001011, 14);
        add_vec(16'b1,    1, 2'd1, 32'b11011100111,    11);
        add_vec(16'b1000, 4, 2'd2, 32'b11011100110000, 14);
`else
        add_vec(16'b1000000, 7, 2'd0, 32'b11011111001011, 14);
        add_vec(16'b1000,    4, 2'd1, 32'b110111,         6);
        add_vec(16'b100000,  6, 2'd2, 32'b11011100,       8);
        add_vec(16'b1000000, 7, 2'd3, 32'b11011111001011, 14);
        add_vec(16'b10,      2, 2'd2, 32'b110,            3);
        add_vec(16'b1,       1, 2'd0, 32'b11,             2);
        add_vec(16'b0,       1, 2'd1, 32'b00,             2);
`endif

        // Reset values
        #1;
        check("rst in_ready",  int'(in_ready),  1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_last",  int'(out_last),  0);
        check("rst busy",      int'(busy),      0);
        check("rst rate_err",  int'(rate_err),  0);
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;

        // Fixed vectors, out_ready held high
        for (int v = 0; v < tbl.size(); v++) run_vec(v, $sformatf("vec%0d", v));

        // Async reset in the middle of a frame with bits pending
        @(negedge sys_clk);
        out_ready = 1'b0; in_valid = 1'b1; in_sof = 1'b1; in_data = 1'b1; rate = 2'd1; in_last = 1'b0;
        @(negedge sys_clk);
        in_sof = 1'b0;
        @(negedge sys_clk);
        in_valid = 1'b0;
        #1;
        check("pre_reset busy",      int'(busy),      1);
        check("pre_reset out_valid", int'(out_valid), 1);
        #1 sys_rstn = 1'b0;
        #1;
        check("mid_reset out_valid", int'(out_valid), 0);
        check("mid_reset busy",      int'(busy),      0);
        check("mid_reset in_ready",  int'(in_ready),  1);
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        out_ready = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(negedge sys_clk);
            #1;
            if (out_valid === 1'b1) vcnt++;
        end
        check("post_reset stray_out_valid", vcnt, 0);
        run_vec(0, "post_reset vec0");

        // sof while busy: partial 3/4 frame, restart, phase and state from zero
        tx_bits.delete(); tx_sof.delete();
        for (int k = 0; k < 14; k++) begin
            tx_bits.push_back(bit'($urandom_range(0, 1)));
            tx_sof.push_back(k == 0 || k == 5);
        end
        tx_bits[0] = 1'b1;
        tx_bits[5] = 1'b1;
        build_expect(2'd2);
        run_frame(2'd2, 30, "sof_restart");
        compare_stream("sof_restart");
        check("sof_restart rate_err_pulses", rerr_cnt, 0);

        // Random frames with random backpressure
        for (int f = 0; f < 5; f++) begin
            len = (f == 0) ? 1000 : $urandom_range(1, 200);
            r = (f == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            tx_bits.delete(); tx_sof.delete();
            for (int k = 0; k < len; k++) begin
                tx_bits.push_back(bit'($urandom_range(0, 1)));
                tx_sof.push_back(k == 0);
            end
            build_expect(r);
            run_frame(r, 30, $sformatf("rand%0d", f));
            compare_stream($sformatf("rand%0d", f));
            check($sformatf("rand%0d rate_err_pulses", f), rerr_cnt, (r == 2'd3) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
